fp_mult_pipe: RTL and testbench

Pipelined, multi-lane signed fixed-point multiplier with valid/ready handshaking. It replaces the combinational `fp_mult` in the skin-tone datapath wherever timing closure or backpressure matters, for example in per-channel colour scaling on R/G/B lanes. Each lane rounds the full-precision product back to the `fp_width`/`fp_frac` format and flags any overflow.

---
 rtl/fp_mult_pipe_pkg.sv | 38 +++
 rtl/fp_round_sat.sv | 54 +++++
 rtl/fp_mult_pipe.sv | 113 +++++++++++
 tb/tb_fp_mult_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pipe_pkg.sv
// ============================================================================
// Module  : fp_mult_pipe_pkg
// Purpose : Shared definitions for the pipelined fixed-point multiplier.
//           It holds the default operand format (width/frac macros), the
//           product-width helpers and the round-half-up constant function.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif

`ifndef FP_FRAC
`define FP_FRAC 8
`endif

package fp_mult_pipe_pkg;

    localparam int c_fp_width   = `FP_WIDTH;
    localparam int c_fp_frac    = `FP_FRAC;
    localparam int c_prod_width = 2 * c_fp_width;

    // Full-precision product width for a given operand width.
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

    // Value added before the right shift so that truncation rounds half up.
    function automatic logic [63:0] round_const(input int frac);
        return 64'd1 << (frac - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_sat.sv
// ============================================================================
// Module  : fp_round_sat
// Purpose : Combinational per-lane rounding and range check. Takes the full
//           signed product, rounds half up to FP_FRAC fractional bits and
//           reports whether the result fits in signed FP_WIDTH.
// Ports   : prod [2*FP_WIDTH] in  - full-precision signed product
//           res  [FP_WIDTH]   out - rounded result (wrapped or clamped)
//           ovf               out - result did not fit in FP_WIDTH
// Config  : FP_MULT_SAT_EN - clamp to the most positive/negative value on
//           overflow; when undefined the low FP_WIDTH bits are passed through.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_sat
    import fp_mult_pipe_pkg::*;
#(
    parameter int FP_WIDTH = c_fp_width,
    parameter int FP_FRAC  = c_fp_frac
) (
    input  logic [2*FP_WIDTH-1:0] prod,
    output logic [FP_WIDTH-1:0]   res,
    output logic                  ovf
);

    localparam int              c_pw  = prod_width(FP_WIDTH);
    localparam logic [c_pw:0]   c_rnd = (c_pw + 1)'(round_const(FP_FRAC));

    // One guard bit above the product so the rounding add can never wrap.
    logic signed [c_pw:0]            w_sum;
    logic signed [c_pw:0]            w_shift;
    logic        [c_pw-FP_WIDTH+1:0] w_upper;
    logic                            w_fits;

    assign w_sum   = $signed({prod[c_pw-1], prod}) + $signed(c_rnd);
    assign w_shift = w_sum >>> FP_FRAC;

    // The value fits when every bit from the result sign bit upward is a copy
    // of that sign bit.
    assign w_upper = w_shift[c_pw:FP_WIDTH-1];
    assign w_fits  = (&w_upper) | ~(|w_upper);
    assign ovf     = ~w_fits;

`ifdef FP_MULT_SAT_EN
    assign res = w_fits      ? w_shift[FP_WIDTH-1:0] :
                 w_shift[c_pw] ? {1'b1, {(FP_WIDTH-1){1'b0}}} :
                                 {1'b0, {(FP_WIDTH-1){1'b1}}};
`else
    assign res = w_shift[FP_WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/fp_mult_pipe.sv
// ============================================================================
// Module  : fp_mult_pipe
// Purpose : Two-stage pipelined multi-lane signed fixed-point multiplier with
//           valid/ready handshaking. S1 registers the full product of every
//           lane, S2 registers the rounded, range-checked result.
// Ports   : clk                   in  - rising-edge clock
//           rst                   in  - asynchronous active-high reset
//           in_valid / in_ready   in/out - operand beat handshake
//           a, b [LANES*FP_WIDTH] in  - packed operands, lane i at
//                                       [i*FP_WIDTH +: FP_WIDTH]
//           out_valid / out_ready out/in - result beat handshake
//           out [LANES*FP_WIDTH]  out - packed rounded products
//           out_ovf [LANES]       out - per-lane overflow of the result beat
// Config  : FP_MULT_SAT_EN - saturate overflowing lanes (see fp_round_sat);
//           latency and handshake are the same in both builds.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mult_pipe
    import fp_mult_pipe_pkg::*;
#(
    parameter int FP_WIDTH = c_fp_width,
    parameter int FP_FRAC  = c_fp_frac,
    parameter int LANES    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*FP_WIDTH-1:0] a,
    input  logic [LANES*FP_WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*FP_WIDTH-1:0] out,
    output logic [LANES-1:0]          out_ovf
);

    localparam int c_pw = prod_width(FP_WIDTH);

    logic                      r_s1_valid;
    logic [LANES*c_pw-1:0]     r_s1_prod;
    logic                      r_s2_valid;
    logic [LANES*FP_WIDTH-1:0] r_out;
    logic [LANES-1:0]          r_ovf;

    logic [LANES*c_pw-1:0]     w_prod;
    logic [LANES*FP_WIDTH-1:0] w_res;
    logic [LANES-1:0]          w_ovf;
    logic                      w_s1_load;
    logic                      w_s2_load;

    // Each stage refills when it is empty or its content moves on in the same
    // cycle. in_ready therefore depends on out_ready but never on in_valid.
    assign w_s2_load = ~r_s2_valid | out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign in_ready  = w_s1_load;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [c_pw-1:0] w_a;
            logic signed [c_pw-1:0] w_b;

            // Sign-extend before multiplying; the exact product of two
            // FP_WIDTH-bit values always fits in the low c_pw bits.
            assign w_a = c_pw'($signed(a[i*FP_WIDTH +: FP_WIDTH]));
            assign w_b = c_pw'($signed(b[i*FP_WIDTH +: FP_WIDTH]));
            assign w_prod[i*c_pw +: c_pw] = w_a * w_b;

            fp_round_sat #(
                .FP_WIDTH (FP_WIDTH),
                .FP_FRAC  (FP_FRAC)
            ) u_round (
                .prod (r_s1_prod[i*c_pw +: c_pw]),
                .res  (w_res[i*FP_WIDTH +: FP_WIDTH]),
                .ovf  (w_ovf[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_ovf      <= '0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_prod <= w_prod;
                end
            end
            // Data only changes when a new beat arrives, so a held result
            // stays stable and a drained stage keeps its last value.
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out <= w_res;
                    r_ovf <= w_ovf;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
// ============================================================================
// Module  : tb_fp_mult_pipe
// Purpose : Self-checking bench for fp_mult_pipe (16.8 format, 3 lanes).
//           Directed vector table, backpressure and reset sequences, and a
//           randomized stream checked against an arithmetic reference model.
// Ports   : none
// Config  : FP_MULT_SAT_EN - selects saturating expected values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mult_pipe;

    localparam int c_w = 16;
    localparam int c_l = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [c_l*c_w-1:0] a;
    logic [c_l*c_w-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [c_l*c_w-1:0] out;
    logic [c_l-1:0]    out_ovf;

    always #5 clk = ~clk;

    fp_mult_pipe #(
        .FP_WIDTH (16),
        .FP_FRAC  (8),
        .LANES    (3)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] o;
        logic [2:0]  ovf;
    } vec_t;

    vec_t        vecs[5];
    logic [50:0] sb_q[$];
    logic        hold_pend;
    logic [50:0] hold_val;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, round half up by floor((p + 128)/256),
    // then range check against signed 16 bits. Returns {ovf[2:0], out[47:0]}.
    function automatic logic [50:0] model(input logic [47:0] ma, input logic [47:0] mb);
        logic [50:0] res;
        res = '0;
        for (int l = 0; l < c_l; l++) begin
            longint      sa, sbv, p, q;
            logic [63:0] qv;
            logic        ov;
            sa  = longint'($signed(ma[l*16 +: 16]));
            sbv = longint'($signed(mb[l*16 +: 16]));
            p   = sa * sbv + 128;
            q   = p / 256;
            if ((p % 256 != 0) && (p < 0)) q = q - 1;
            ov  = (q > 32767) || (q < -32768);
            qv  = q;
            res[48 + l] = ov;
`ifdef FP_MULT_SAT_EN
            if (ov) res[l*16 +: 16] = (q > 0) ? 16'h7FFF : 16'h8000;
            else    res[l*16 +: 16] = qv[15:0];
`else
            res[l*16 +: 16] = qv[15:0];
`endif
        end
        return res;
    endfunction

    function automatic logic [47:0] rand_op();
        logic [47:0] r;
        for (int l = 0; l < c_l; l++) begin
            if ($urandom_range(0, 1) == 0) r[l*16 +: 16] = 16'($urandom);
            else r[l*16 +: 16] = 16'($urandom_range(0, 2047)) - 16'd1024;
        end
        return r;
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample the
    // handshake just before the rising edge and update the scoreboard.
    task automatic cycle(input logic iv, input logic [47:0] ia, input logic [47:0] ib,
                         input logic ordy, output logic acc, output logic emit);
        logic [50:0] exp;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (hold_pend && out_valid) check("hold_stable", {13'd0, out_ovf, out}, {13'd0, hold_val});
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_ovf, out};
        if (acc) sb_q.push_back(model(ia, ib));
        if (emit) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {13'd0, out_ovf, out}, 64'hDEAD);
            end else begin
                exp = sb_q.pop_front();
                check("stream_out", {13'd0, out_ovf, out}, {13'd0, exp});
            end
        end
    endtask

    initial begin
        logic        acc, emit;
        int          idx;
        logic [47:0] bpa[5];
        logic [47:0] bpb[5];

        // {lane2, lane1, lane0}
        vecs[0] = '{a: {16'h0500, 16'h0500, 16'h0500}, b: {16'h0500, 16'h0500, 16'h0500},
                    o: {16'h1900, 16'h1900, 16'h1900}, ovf: 3'b000};
        vecs[1] = '{a: {16'hFF00, 16'h0200, 16'h0180}, b: {16'hFF00, 16'h0300, 16'hFE00},
                    o: {16'h0100, 16'h0600, 16'hFD00}, ovf: 3'b000};
        vecs[2] = '{a: {16'hFFFF, 16'h0001, 16'h0001}, b: {16'h0080, 16'h007F, 16'h0080},
                    o: {16'h0000, 16'h0000, 16'h0001}, ovf: 3'b000};
`ifdef FP_MULT_SAT_EN
        vecs[3] = '{a: {16'h0100, 16'h8100, 16'h7F00}, b: {16'h7FFF, 16'h0200, 16'h0200},
                    o: {16'h7FFF, 16'h8000, 16'h7FFF}, ovf: 3'b011};
        vecs[4] = '{a: {16'hFF80, 16'h8000, 16'h8000}, b: {16'h0001, 16'h8000, 16'h0100},
                    o: {16'h0000, 16'h7FFF, 16'h8000}, ovf: 3'b010};
`else
        vecs[3] = '{a: {16'h0100, 16'h8100, 16'h7F00}, b: {16'h7FFF, 16'h0200, 16'h0200},
                    o: {16'h7FFF, 16'h0200, 16'hFE00}, ovf: 3'b011};
        vecs[4] = '{a: {16'hFF80, 16'h8000, 16'h8000}, b: {16'h0001, 16'h8000, 16'h0100},
                    o: {16'h0000, 16'h0000, 16'h8000}, ovf: 3'b010};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        hold_pend = 1'b0;
        hold_val  = '0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out", 64'(out), 64'd0);
        check("reset_ovf", 64'(out_ovf), 64'd0);
        rst = 1'b0;

        // Directed table: one beat each, two-cycle latency.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            a         = vecs[i].a;
            b         = vecs[i].b;
            out_ready = 1'b1;
            #1 check("vec_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1 check("vec_lat1_idle", 64'(out_valid), 64'd0);
            @(negedge clk);
            #1;
            check("vec_valid", 64'(out_valid), 64'd1);
            check("vec_out", 64'(out), 64'(vecs[i].o));
            check("vec_ovf", 64'(out_ovf), 64'(vecs[i].ovf));
        end
        cycle(1'b0, '0, '0, 1'b1, acc, emit);

        // Backpressure: 4 cycles with out_ready low, then release.
        for (int i = 0; i < 5; i++) begin
            bpa[i] = rand_op();
            bpb[i] = rand_op();
        end
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, bpa[idx], bpb[idx], 1'b0, acc, emit);
            check("bp_in_ready", 64'(in_ready), (k < 2) ? 64'd1 : 64'd0);
            if (acc) idx++;
        end
        check("bp_accepts", 64'(idx), 64'd2);
        for (int k = 0; k < 5; k++) begin
            cycle(idx < 5, bpa[(idx < 5) ? idx : 0], bpb[(idx < 5) ? idx : 0], 1'b1, acc, emit);
            check("bp_no_gap", 64'(emit), 64'd1);
            if (acc) idx++;
        end
        check("bp_all_accepted", 64'(idx), 64'd5);
        check("bp_all_emitted", 64'(sb_q.size()), 64'd0);

        // Reset with two beats in flight.
        cycle(1'b1, rand_op(), rand_op(), 1'b0, acc, emit);
        cycle(1'b1, rand_op(), rand_op(), 1'b0, acc, emit);
        @(posedge clk);
        #2;
        check("rst_pre_full", 64'({out_valid, in_ready}), 64'b10);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        hold_pend = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, '0, '0, 1'b1, acc, emit);
            check("rst_no_stale", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
        end
        cycle(1'b1, {16'h0300, 16'h0200, 16'h0100}, {16'h0100, 16'h0100, 16'h0100}, 1'b1, acc, emit);
        check("rst_accept", 64'(acc), 64'd1);
        cycle(1'b0, '0, '0, 1'b1, acc, emit);
        check("rst_lat1_idle", 64'(out_valid), 64'd0);
        cycle(1'b0, '0, '0, 1'b1, acc, emit);
        check("rst_lat2_valid", 64'(out_valid), 64'd1);
        check("rst_lat2_out", 64'(out), 64'h0003_0002_0001 << 8);

        // Randomized stream against the reference model.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) != 0, rand_op(), rand_op(),
                  $urandom_range(0, 3) != 0, acc, emit);
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, '0, '0, 1'b1, acc, emit);
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        check("drain_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
